navigate_gen: RTL and testbench
===============================

Name: navigate_gen

Overview:
Parametrised next-generation navigation sequencer. It sits between the maze-solver command layer and the PID/inertial blocks. It runs heading changes and forward moves, and produces a ramped unsigned forward-speed setpoint. Over the fixed-function navigator it adds:
- configurable speed width, limits and ramp rates
- skipping the first N qualifying side openings before stopping
- saturating acceleration
- front-wall priority over side openings
- an optional move watchdog

Parameters:
SPD_W, 11, width of frwrd_spd
MAX_SPD, 11'h2A0, acceleration ceiling (clamped, never exceeded)
MIN_SPD, 11'h0D0, speed loaded on move start
ACC_INC, 11'h018, increment per hdng_rdy in ACCEL
DEC_SHIFT, 1, slow-decel step = ACC_INC<<DEC_SHIFT
FAST_SHIFT, 3, fast-decel step = ACC_INC<<FAST_SHIFT
SKIP_W, 3, width of opn_skip
TMO_CYC, 32'd50_000_000, watchdog limit in clk cycles (used only with NAV_TMO_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
strt_hdng  input  1  start heading change (sampled only in IDLE)
strt_mv  input  1  start forward move (sampled only in IDLE)
stp_lft  input  1  stop qualifier: left openings count
stp_rght  input  1  stop qualifier: right openings count
opn_skip  input  SKIP_W  qualifying openings to pass before stopping; latched on move start
hdng_rdy  input  1  speed-update pacing strobe
at_hdng  input  1  PID heading-reached flag
lft_opn  input  1  IR left opening
rght_opn  input  1  IR right opening
frwrd_opn  input  1  IR forward clear
frwrd_spd  output  SPD_W  forward-speed setpoint
moving  output  1  high in HDNG/ACCEL/DEC/DEC_FAST
en_fusion  output  1  moving && frwrd_spd > (MAX_SPD>>1)
mv_cmplt  output  1  one-cycle completion pulse
nav_err  output  1  one-cycle watchdog-abort pulse

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, frwrd_spd=0, skip counter=0, edge registers (at_hdng, lft_opn, rght_opn previous values)=0, watchdog=0.
  - moving, en_fusion, mv_cmplt and nav_err are 0 during and after reset.
  - Reset mid-move takes effect at the next edge with no completion pulse.
- States: IDLE, HDNG, ACCEL, DEC, DEC_FAST.
- IDLE:
  - strt_hdng -> HDNG.
  - else strt_mv -> ACCEL; frwrd_spd<=MIN_SPD and skip counter<=opn_skip on the same edge.
  - Both asserted together: heading wins. Both strobes are ignored outside IDLE.
- HDNG: on the rising edge of at_hdng (at_hdng & ~prev) -> IDLE with mv_cmplt=1 that cycle. at_hdng already high on entry does not complete the heading; a fresh rise is required.
- ACCEL:
  - On hdng_rdy, frwrd_spd<=min(frwrd_spd+ACC_INC, MAX_SPD).
  - Qualifying opening = (lft rise & stp_lft) | (rght rise & stp_rght); simultaneous left and right rises count as one opening.
  - Priority:
    1. ~frwrd_opn -> DEC_FAST.
    2. Qualifying opening with counter==0 -> DEC.
    3. Qualifying opening with counter>0 -> counter decrements, stay in ACCEL.
- DEC / DEC_FAST:
  - On hdng_rdy, step S = slow or fast step. If frwrd_spd>S, subtract S; else frwrd_spd<=0.
  - In the cycle frwrd_spd==0 -> IDLE with mv_cmplt=1. No hdng_rdy means no speed change.
  - A front-wall closure during DEC does not switch to DEC_FAST.
- All speed arithmetic is unsigned SPD_W; no wrap-around in either direction.
- mv_cmplt and nav_err are combinational in the exit cycle, exactly one cycle wide, never both high in the same cycle.

Optional Feature:
NAV_TMO_EN:
- When defined, a cycle counter clears in IDLE and increments in every other state.
- On reaching TMO_CYC-1, at the next edge: state<=IDLE, frwrd_spd<=0, nav_err=1 for that cycle, no mv_cmplt.
- A timeout coinciding with normal completion: completion wins.
- When undefined, there is no counter and nav_err is tied to 0.

Test Plan:
1. Reset, then strt_mv with opn_skip=0 and frwrd_opn=1; pulse hdng_rdy 20 times -> frwrd_spd D0, E8, ... 298, then clamps at 2A0. en_fusion high once frwrd_spd>150.
2. At 2A0, stp_lft=1 and lft_opn rises -> DEC. 14 hdng_rdy pulses step 2A0 down by 30 to 0. mv_cmplt is a single pulse; then IDLE, moving=0.
3. At 2A0, drop frwrd_opn -> DEC_FAST. Speed sequence 1E0, 120, 60, 0 over 4 hdng_rdy pulses, then mv_cmplt.
4. opn_skip=2, stp_rght=1, three right-opening rises -> first two ignored, third enters DEC. Simultaneous lft rise and rght rise with both stop qualifiers set count once. Wall drop in the same cycle as the opening -> DEC_FAST.
5. strt_hdng and strt_mv together -> HDNG, frwrd_spd stays 0. at_hdng held high from entry -> no completion; drop then raise at_hdng -> mv_cmplt pulse.
6. With NAV_TMO_EN and TMO_CYC=100: HDNG with at_hdng never rising -> after 100 cycles nav_err pulse, state IDLE. Repeat with rst_n low mid-ACCEL -> frwrd_spd=0 next edge, no pulses.

Source files
------------

// File: rtl/navigate_gen.sv
// Navigation sequencer: heading changes, ramped forward moves, opening skip and front-wall priority.
// Optional move watchdog is compiled in when NAV_TMO_EN is defined; otherwise nav_err is tied low.
module navigate_gen #(
    parameter int               SPD_W      = 11,
    parameter logic [SPD_W-1:0] MAX_SPD    = 11'h2A0,
    parameter logic [SPD_W-1:0] MIN_SPD    = 11'h0D0,
    parameter logic [SPD_W-1:0] ACC_INC    = 11'h018,
    parameter int               DEC_SHIFT  = 1,
    parameter int               FAST_SHIFT = 3,
    parameter int               SKIP_W     = 3,
    parameter logic [31:0]      TMO_CYC    = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_hdng,
    input  logic              strt_mv,
    input  logic              stp_lft,
    input  logic              stp_rght,
    input  logic [SKIP_W-1:0] opn_skip,
    input  logic              hdng_rdy,
    input  logic              at_hdng,
    input  logic              lft_opn,
    input  logic              rght_opn,
    input  logic              frwrd_opn,
    output logic [SPD_W-1:0]  frwrd_spd,
    output logic              moving,
    output logic              en_fusion,
    output logic              mv_cmplt,
    output logic              nav_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDNG,
        ACCEL,
        DEC,
        DEC_FAST
    } state_t;

    localparam logic [SPD_W-1:0] SLOW_STEP = ACC_INC << DEC_SHIFT;
    localparam logic [SPD_W-1:0] FAST_STEP = ACC_INC << FAST_SHIFT;
    localparam logic [SPD_W-1:0] FUSE_THR  = MAX_SPD >> 1;

    // Reject configurations that would make the ramp or watchdog meaningless.
    if (MIN_SPD > MAX_SPD) begin : g_bad_min_spd
        $error("navigate_gen: MIN_SPD exceeds MAX_SPD");
    end
    if (TMO_CYC < 32'd2) begin : g_bad_tmo_cyc
        $error("navigate_gen: TMO_CYC must be at least 2");
    end

    function automatic logic [SPD_W-1:0] sat_add(
        input logic [SPD_W-1:0] a,
        input logic [SPD_W-1:0] b,
        input logic [SPD_W-1:0] lim
    );
        logic [SPD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            sat_add = lim;
        end else begin
            sat_add = sum[SPD_W-1:0];
        end
    endfunction

    function automatic logic [SPD_W-1:0] sat_sub(
        input logic [SPD_W-1:0] a,
        input logic [SPD_W-1:0] s
    );
        if (a > s) begin
            sat_sub = a - s;
        end else begin
            sat_sub = '0;
        end
    endfunction

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic              at_hdng_prev;
    logic              lft_prev;
    logic              rght_prev;

    logic hdng_rise;
    logic opn_qual;
    logic hdng_done;
    logic dec_done;
    logic cmplt;
    logic tmo_hit;

    assign hdng_rise = at_hdng & ~at_hdng_prev;
    // Simultaneous left and right rises collapse into one opening.
    assign opn_qual  = (lft_opn & ~lft_prev & stp_lft) | (rght_opn & ~rght_prev & stp_rght);
    assign hdng_done = (state == HDNG) && hdng_rise;
    assign dec_done  = ((state == DEC) || (state == DEC_FAST)) && (frwrd_spd == '0);
    assign cmplt     = hdng_done | dec_done;

`ifdef NAV_TMO_EN
    logic [31:0] wdog;

    // Normal completion takes precedence over a coincident timeout.
    assign tmo_hit = (state != IDLE) && (wdog == (TMO_CYC - 32'd1)) && !cmplt;

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign moving    = rst_n && (state != IDLE);
    assign en_fusion = moving && (frwrd_spd > FUSE_THR);
    assign mv_cmplt  = rst_n && cmplt;
    assign nav_err   = rst_n && tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            frwrd_spd    <= '0;
            skip_cnt     <= '0;
            at_hdng_prev <= 1'b0;
            lft_prev     <= 1'b0;
            rght_prev    <= 1'b0;
        end else begin
            at_hdng_prev <= at_hdng;
            lft_prev     <= lft_opn;
            rght_prev    <= rght_opn;
            if (tmo_hit) begin
                state     <= IDLE;
                frwrd_spd <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (strt_hdng) begin
                            state <= HDNG;
                        end else if (strt_mv) begin
                            state     <= ACCEL;
                            frwrd_spd <= MIN_SPD;
                            skip_cnt  <= opn_skip;
                        end
                    end
                    HDNG: begin
                        if (hdng_rise) begin
                            state <= IDLE;
                        end
                    end
                    ACCEL: begin
                        if (hdng_rdy) begin
                            frwrd_spd <= sat_add(frwrd_spd, ACC_INC, MAX_SPD);
                        end
                        // A closing front wall outranks any side opening.
                        if (!frwrd_opn) begin
                            state <= DEC_FAST;
                        end else if (opn_qual) begin
                            if (skip_cnt == '0) begin
                                state <= DEC;
                            end else begin
                                skip_cnt <= skip_cnt - 1'b1;
                            end
                        end
                    end
                    DEC, DEC_FAST: begin
                        if (frwrd_spd == '0) begin
                            state <= IDLE;
                        end else if (hdng_rdy) begin
                            frwrd_spd <= sat_sub(frwrd_spd, (state == DEC) ? SLOW_STEP : FAST_STEP);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        frwrd_spd <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_navigate_gen.sv
// Scoreboard bench for navigate_gen: expected speeds are queued when hdng_rdy is driven and
// compared once the update edge has passed; control outputs are checked at fixed points.
module tb_navigate_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght;
    logic [2:0]  opn_skip;
    logic        hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn;
    logic [10:0] frwrd_spd;
    logic        moving, en_fusion, mv_cmplt, nav_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          model_spd;
    int          mode;          // 0 accelerate, 1 slow decel, 2 fast decel

    navigate_gen #(.TMO_CYC(32'd100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .opn_skip  (opn_skip),
        .hdng_rdy  (hdng_rdy),
        .at_hdng   (at_hdng),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .frwrd_spd (frwrd_spd),
        .moving    (moving),
        .en_fusion (en_fusion),
        .mv_cmplt  (mv_cmplt),
        .nav_err   (nav_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdy_pulse();
        int e;
        case (mode)
            0:       e = (model_spd + 'h18 > 'h2A0) ? 'h2A0 : model_spd + 'h18;
            1:       e = (model_spd > 'h30) ? model_spd - 'h30 : 0;
            default: e = (model_spd > 'hC0) ? model_spd - 'hC0 : 0;
        endcase
        model_spd = e;
        exp_q.push_back(32'(e));
        hdng_rdy = 1'b1;
        tick();
        hdng_rdy = 1'b0;
        check("spd", 32'(frwrd_spd), exp_q.pop_front());
        check("en_fusion", 32'(en_fusion), 32'(model_spd > 'h150));
    endtask

    task automatic start_mv(input int skip);
        opn_skip = 3'(skip);
        strt_mv  = 1'b1;
        exp_q.push_back(32'h0D0);
        tick();
        strt_mv   = 1'b0;
        model_spd = 'hD0;
        mode      = 0;
        check("start_spd", 32'(frwrd_spd), exp_q.pop_front());
        check("start_moving", 32'(moving), 32'd1);
    endtask

    task automatic opn_rise(input logic l, input logic r, input logic wall_drop);
        lft_opn  = l;
        rght_opn = r;
        if (wall_drop) frwrd_opn = 1'b0;
        tick();
        frwrd_opn = 1'b1;
        lft_opn   = 1'b0;
        rght_opn  = 1'b0;
        tick();
    endtask

    task automatic finish_dec();
        for (int i = 0; i < 64 && model_spd != 0; i++) begin
            rdy_pulse();
            if (model_spd != 0) check("no_early_cmplt", 32'(mv_cmplt), 32'd0);
        end
        check("cmplt_pulse", 32'(mv_cmplt), 32'd1);
        check("cmplt_no_err", 32'(nav_err), 32'd0);
        tick();
        check("cmplt_one_cycle", 32'(mv_cmplt), 32'd0);
        check("idle_after_move", 32'(moving), 32'd0);
    endtask

    initial begin
        logic [31:0] fast_tab [4];
        int          n;
        fast_tab = '{32'h1E0, 32'h120, 32'h060, 32'h000};

        rst_n = 1'b0; strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;
        opn_skip = 3'd0; hdng_rdy = 1'b0; at_hdng = 1'b0; lft_opn = 1'b0; rght_opn = 1'b0;
        frwrd_opn = 1'b1; model_spd = 0; mode = 0;
        repeat (3) tick();
        check("rst_spd", 32'(frwrd_spd), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_fusion", 32'(en_fusion), 32'd0);
        check("rst_cmplt", 32'(mv_cmplt), 32'd0);
        check("rst_err", 32'(nav_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ramp to ceiling, then slow decel on a left opening.
        start_mv(0);
        for (int i = 0; i < 19; i++) rdy_pulse();
        check("ramp_298", 32'(frwrd_spd), 32'h298);
        rdy_pulse();
        check("ramp_clamp", 32'(frwrd_spd), 32'h2A0);
        rdy_pulse();
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        check("strt_mv_ignored", 32'(frwrd_spd), 32'h2A0);
        tick();
        check("no_rdy_no_change", 32'(frwrd_spd), 32'h2A0);
        stp_lft = 1'b1;
        opn_rise(1'b1, 1'b0, 1'b0);
        stp_lft = 1'b0;
        mode = 1;
        check("dec_moving", 32'(moving), 32'd1);
        frwrd_opn = 1'b0;
        rdy_pulse();
        check("dec_wall_stays_slow", 32'(frwrd_spd), 32'h270);
        frwrd_opn = 1'b1;
        finish_dec();

        // Front wall while at ceiling -> fast decel.
        start_mv(0);
        for (int i = 0; i < 20; i++) rdy_pulse();
        frwrd_opn = 1'b0;
        tick();
        frwrd_opn = 1'b1;
        mode = 2;
        for (int i = 0; i < 4; i++) begin
            rdy_pulse();
            check("fast_tab", 32'(frwrd_spd), fast_tab[i]);
        end
        finish_dec();

        // Skip two right openings, stop on the third.
        stp_rght = 1'b1;
        start_mv(2);
        rdy_pulse();
        opn_rise(1'b0, 1'b1, 1'b0);
        rdy_pulse();
        opn_rise(1'b0, 1'b1, 1'b0);
        rdy_pulse();
        opn_rise(1'b0, 1'b1, 1'b0);
        mode = 1;
        rdy_pulse();
        finish_dec();

        // Simultaneous left/right rise counts once.
        stp_lft = 1'b1;
        start_mv(1);
        opn_rise(1'b1, 1'b1, 1'b0);
        rdy_pulse();
        opn_rise(1'b0, 1'b1, 1'b0);
        mode = 1;
        rdy_pulse();
        finish_dec();

        // Wall drop coinciding with a qualifying opening.
        start_mv(0);
        rdy_pulse();
        opn_rise(1'b1, 1'b0, 1'b1);
        mode = 2;
        rdy_pulse();
        finish_dec();
        stp_lft = 1'b0;
        stp_rght = 1'b0;

        // Heading wins over move; at_hdng high on entry does not complete.
        at_hdng = 1'b1; strt_hdng = 1'b1; strt_mv = 1'b1;
        tick();
        strt_hdng = 1'b0; strt_mv = 1'b0;
        check("hdng_moving", 32'(moving), 32'd1);
        check("hdng_spd", 32'(frwrd_spd), 32'd0);
        repeat (3) tick();
        check("hdng_held_no_cmplt", 32'(mv_cmplt), 32'd0);
        check("hdng_held_moving", 32'(moving), 32'd1);
        at_hdng = 1'b0;
        tick();
        at_hdng = 1'b1;
        #1;
        check("hdng_cmplt", 32'(mv_cmplt), 32'd1);
        tick();
        check("hdng_cmplt_one_cycle", 32'(mv_cmplt), 32'd0);
        check("hdng_idle", 32'(moving), 32'd0);
        at_hdng = 1'b0;
        tick();

        // Heading that never completes.
        strt_hdng = 1'b1;
        tick();
        strt_hdng = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (nav_err) break;
            tick();
            n++;
        end
`ifdef NAV_TMO_EN
        check("tmo_cycles", 32'(n), 32'd99);
        check("tmo_err", 32'(nav_err), 32'd1);
        check("tmo_no_cmplt", 32'(mv_cmplt), 32'd0);
        tick();
        check("tmo_err_one_cycle", 32'(nav_err), 32'd0);
        check("tmo_idle", 32'(moving), 32'd0);
`else
        check("no_tmo_err", 32'(nav_err), 32'd0);
        check("no_tmo_still_moving", 32'(moving), 32'd1);
        at_hdng = 1'b1;
        tick();
        at_hdng = 1'b0;
        check("no_tmo_hdng_done", 32'(moving), 32'd0);
`endif

        // Reset in the middle of a move.
        start_mv(0);
        for (int i = 0; i < 12; i++) rdy_pulse();
        rst_n = 1'b0;
        #1;
        check("midrst_cmplt", 32'(mv_cmplt), 32'd0);
        check("midrst_err", 32'(nav_err), 32'd0);
        tick();
        check("midrst_spd", 32'(frwrd_spd), 32'd0);
        check("midrst_moving", 32'(moving), 32'd0);
        check("midrst_fusion", 32'(en_fusion), 32'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle_cmplt", 32'(mv_cmplt), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
